// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace packer: stored record layout, serialiser
// word states and header bit positions.
package ibex_trace_pkg;

   localparam int unsigned HdrDropBit  = 31;
   localparam int unsigned HdrTrapBit  = 30;
   localparam int unsigned HdrIntrBit  = 29;
   localparam int unsigned HdrModeLsb  = 27;
   localparam int unsigned HdrRdLsb    = 22;
   localparam int unsigned HdrOrderLsb = 0;
   localparam int unsigned OrderW      = 16;

   typedef struct packed {
      logic        drop;
      logic        trap;
      logic        intr;
      logic [1:0]  mode;
      logic [4:0]  rd_addr;
      logic [5:0]  rsvd;
      logic [15:0] order;
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] wdata;
   } trace_rec_t;

   typedef enum logic [2:0] {
      TW_IDLE,
      TW_HDR,
      TW_PC,
      TW_INSN,
      TW_WDATA
   } trace_word_e;

   function automatic logic [31:0] hdr_word(input trace_rec_t rec);
      logic [31:0] w;
      w                        = '0;
      w[HdrDropBit]            = rec.drop;
      w[HdrTrapBit]            = rec.trap;
      w[HdrIntrBit]            = rec.intr;
      w[HdrModeLsb +: 2]       = rec.mode;
      w[HdrRdLsb +: 5]         = rec.rd_addr;
      w[HdrOrderLsb +: OrderW] = rec.order;
      return w;
   endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Depth-entry record FIFO; head is the registered entry at rd_ptr, a push is
// visible at the head one cycle later. Caller must not push when full or pop when empty.
module ibex_trace_rec_fifo
   import ibex_trace_pkg::*;
#(
   parameter int unsigned Depth = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  trace_rec_t                   push_rec_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output trace_rec_t                   head_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   trace_rec_t      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   // Depth is a power of two, so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_rec_i;
   end

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ibex_rvfi_trace_packer.sv
// Captures one record per RVFI retirement and serialises it as HDR/PC/INSN/WDATA words;
// HDR valid two edges after capture, output held under backpressure, full-FIFO retirements dropped.
module ibex_rvfi_trace_packer
   import ibex_trace_pkg::*;
#(
   parameter int unsigned Depth        = 8,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    trace_en_i,
   input  logic                    rvfi_valid,
   input  logic [63:0]             rvfi_order,
   input  logic [31:0]             rvfi_insn,
   input  logic                    rvfi_trap,
   input  logic                    rvfi_intr,
   input  logic [1:0]              rvfi_mode,
   input  logic [4:0]              rvfi_rd_addr,
   input  logic [31:0]             rvfi_rd_wdata,
   input  logic [31:0]             rvfi_pc_rdata,
   output logic                    trace_valid_o,
   input  logic                    trace_ready_i,
   output logic [31:0]             trace_data_o,
   output logic                    trace_last_o,
   output logic [DropCntWidth-1:0] drop_cnt_o,
   output logic                    fifo_full_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);

   trace_rec_t              push_rec, head_rec;
   logic [CntW-1:0]         count;
   logic                    full, empty;
   logic                    capture, push, drop, fire, pop;
   trace_word_e             state_q, state_d;
   logic                    valid_q, last_q;
   logic                    drop_pend_q, drop_pend_d;
   logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
   logic [31:0]             trace_data;
   logic                    unused_order;

   assign unused_order = ^rvfi_order[63:16];

   assign capture = rvfi_valid && trace_en_i;
   assign push    = capture && !full;
   assign drop    = capture && full;
   assign fire    = valid_q && trace_ready_i;
   assign pop     = fire && (state_q == TW_WDATA);

   always_comb begin
      push_rec         = '0;
      push_rec.drop    = drop_pend_q;
      push_rec.trap    = rvfi_trap;
      push_rec.intr    = rvfi_intr;
      push_rec.mode    = rvfi_mode;
      push_rec.rd_addr = rvfi_rd_addr;
      push_rec.order   = rvfi_order[15:0];
      push_rec.pc      = rvfi_pc_rdata;
      push_rec.insn    = rvfi_insn;
      push_rec.wdata   = rvfi_rd_wdata;
   end

   ibex_trace_rec_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push),
      .push_rec_i (push_rec),
      .pop_i      (pop),
      .full_o     (full),
      .empty_o    (empty),
      .head_o     (head_rec),
      .count_o    (count)
   );

   // A push landing on the last pop keeps the serialiser busy without a bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TW_IDLE:  if (!empty) state_d = TW_HDR;
         TW_HDR:   if (fire)   state_d = TW_PC;
         TW_PC:    if (fire)   state_d = TW_INSN;
         TW_INSN:  if (fire)   state_d = TW_WDATA;
         TW_WDATA: if (fire)   state_d = ((count > CntW'(1)) || push) ? TW_HDR : TW_IDLE;
         default:              state_d = TW_IDLE;
      endcase
   end

   always_comb begin
      drop_pend_d = drop_pend_q;
      drop_cnt_d  = drop_cnt_q;
      if (drop) begin
         drop_pend_d = 1'b1;
         if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
      end else if (push) begin
         drop_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= TW_IDLE;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         drop_pend_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= (state_d != TW_IDLE);
         last_q      <= (state_d == TW_WDATA);
         drop_pend_q <= drop_pend_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   always_comb begin
      trace_data = '0;
      case (state_q)
         TW_HDR:   trace_data = hdr_word(head_rec);
         TW_PC:    trace_data = head_rec.pc;
         TW_INSN:  trace_data = head_rec.insn;
         TW_WDATA: trace_data = head_rec.wdata;
         default:  trace_data = '0;
      endcase
   end

   assign trace_valid_o = valid_q;
   assign trace_last_o  = last_q;
   assign trace_data_o  = trace_data;
   assign drop_cnt_o    = drop_cnt_q;
   assign fifo_full_o   = full;

endmodule
